// File: rtl/clk_div_cfg_if.sv
// ============================================================================
// clk_div_cfg_if : divisor-update request bus and divider feedback/control
// Rev 1.0
// ============================================================================
`default_nettype none

interface clk_div_cfg_if;
  logic        i_wr_valid;
  logic [15:0] i_wr_divisor;
  logic        o_wr_ready;
  logic        i_ramp_en;
  logic        i_div_clk;
  logic [15:0] o_divisor;
  logic        o_busy;
  logic        o_err;

  modport slave (
    input  i_wr_valid, i_wr_divisor, i_ramp_en, i_div_clk,
    output o_wr_ready, o_divisor, o_busy, o_err
  );

  modport master (
    output i_wr_valid, i_wr_divisor, i_ramp_en, i_div_clk,
    input  o_wr_ready, o_divisor, o_busy, o_err
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_cfg.sv
// ============================================================================
// clk_div_cfg : glitch-safe divisor updater for an even clock divider
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_cfg #(
  parameter logic [15:0] RESET_DIV = 16'd4,
  parameter logic [15:0] MAX_DIV   = 16'd1024,
  parameter logic [15:0] RAMP_STEP = 16'd2,
  parameter logic [17:0] TIMEOUT   = 18'd2052
) (
  input  logic          i_clk,
  input  logic          i_rst,
  clk_div_cfg_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    RAMP      = 2'd2
  } state_t;

  localparam logic [17:0] C_TMO_LAST = TIMEOUT - 18'd1;

  state_t      state_q,   state_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] target_q,  target_d;
  logic        ramp_q,    ramp_d;
  logic        prev_q,    prev_d;
  logic [17:0] tmo_q,     tmo_d;
  logic        err_q,     err_d;

  logic        w_fall;
  logic [16:0] w_up_sum;
  logic [16:0] w_dn_lim;
  logic [15:0] w_step_val;
  logic [15:0] w_upd_val;

  assign w_fall = prev_q && !bus.i_div_clk;

  // One ramp step toward the target; 17-bit sums make the clamp wrap-free.
  always_comb begin
    w_up_sum   = {1'b0, divisor_q} + {1'b0, RAMP_STEP};
    w_dn_lim   = {1'b0, target_q}  + {1'b0, RAMP_STEP};
    w_step_val = target_q;
    if (target_q > divisor_q) begin
      if (w_up_sum < {1'b0, target_q}) begin
        w_step_val = w_up_sum[15:0];
      end
    end else begin
      if ({1'b0, divisor_q} > w_dn_lim) begin
        w_step_val = divisor_q - RAMP_STEP;
      end
    end
    if (!ramp_q || divisor_q == 16'd0 || target_q == 16'd0) begin
      w_upd_val = target_q;
    end else begin
      w_upd_val = w_step_val;
    end
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    target_d  = target_q;
    ramp_d    = ramp_q;
    prev_d    = bus.i_div_clk;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_wr_valid) begin
          if (bus.i_wr_divisor > MAX_DIV) begin
            err_d = 1'b1;
          end else if (bus.i_wr_divisor != divisor_q) begin
            target_d = bus.i_wr_divisor;
            ramp_d   = bus.i_ramp_en;
            // In bypass the divider has no edges to wait for.
            if (divisor_q == 16'd0) begin
              divisor_d = bus.i_wr_divisor;
            end else begin
              state_d = WAIT_EDGE;
              tmo_d   = 18'd0;
            end
          end
        end
      end
      WAIT_EDGE: begin
        tmo_d = tmo_q + 18'd1;
        if (w_fall || tmo_q == C_TMO_LAST) begin
          divisor_d = w_upd_val;
          state_d   = (w_upd_val == target_q) ? IDLE : RAMP;
        end
      end
      RAMP: begin
        state_d = WAIT_EDGE;
        tmo_d   = 18'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      divisor_q <= RESET_DIV;
      target_q  <= RESET_DIV;
      ramp_q    <= 1'b0;
      prev_q    <= 1'b0;
      tmo_q     <= 18'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      target_q  <= target_d;
      ramp_q    <= ramp_d;
      prev_q    <= prev_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_wr_ready = (state_q == IDLE);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_divisor  = divisor_q;
  assign bus.o_err      = err_q;

endmodule

`default_nettype wire
